alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Initiator-side controller for the 32-bit ALU (`my_alu`). It accepts one operation at a time over a valid/ready request channel and drives the operands and `ALUop` onto the ALU. It waits a fixed latency: one cycle for single-cycle ops, `MOD_CYCLES` cycles for the iterative modulo unit. It then captures `R` and returns it over a valid/ready response channel. It sits between the datapath sequencer and the ALU instance.

## Interface
- `MOD_CYCLES`, default 34: cycles the modulo unit needs after its restart pulse before `R` is valid; legal range is 1..255.
- `clk`  in  1  : single clock; all state changes on the rising edge.
- `reset`  in  1  : asynchronous, active-low reset.
- `req_valid`  in  1  : request present.
- `req_ready`  out  1  : controller can accept a request.
- `req_op`  in  3  : ALU operation code.
- `req_a`, `req_b`  in  32 each  : operands.
- `alu_a`, `alu_b`  out  32 each  : operands driven to the ALU.
- `alu_op`  out  3  : `ALUop` driven to the ALU.
- `mod_restart`  out  1  : one-cycle active-high pulse that restarts the modulo unit.
- `alu_r`  in  32  : ALU result `R`.
- `rsp_valid`  out  1  : response present.
- `rsp_ready`  in  1  : consumer accepts the response.
- `rsp_data`  out  32  : captured result.
- `rsp_err`  out  1  : set when the request was MOD with B = 0.
- `op_count`  out  16  : number of completed responses; wraps at 16 bits.

## Operation
- Op codes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ADD
  - 101 SUB
  - 110 SLT
  - 111 MOD
- States: IDLE, EXEC, RESTART, WAIT_MOD, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, `req_a`, `req_b` and `req_op` are registered into `alu_a`, `alu_b` and `alu_op`.
  - If the op is MOD and `req_b` = 0, go to RESP with `rsp_err` = 1 and `rsp_data` = 0. The ALU is not exercised.
  - Otherwise, if the op is MOD, go to RESTART.
  - Otherwise, go to EXEC.
- EXEC: capture `alu_r` into `rsp_data` with `rsp_err` = 0, then go to RESP.
- RESTART: `mod_restart` = 1 for exactly this cycle; the wait counter loads `MOD_CYCLES`; then go to WAIT_MOD.
- WAIT_MOD:
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, capture `alu_r` and go to RESP.
  - The state lasts exactly `MOD_CYCLES` cycles.
- RESP:
  - `rsp_valid` = 1, and `rsp_data`/`rsp_err` are held stable until `rsp_ready`.
  - On the handshake, `op_count` increments and the state goes to IDLE.
  - No new request is accepted in the same cycle.
- `req_ready` = 0 in every state except IDLE; the controller allows a single outstanding operation.
- `alu_a`, `alu_b` and `alu_op` hold their last values while IDLE; they are never changed mid-operation.
- Arithmetic width: the controller performs no arithmetic on operands. The wait counter is 8 bits. `op_count` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `mod_restart` = 0, `alu_a`/`alu_b` = 0, `alu_op` = 000, `op_count` = 0.
- Latency is measured from the request handshake at the edge ending cycle t:
  - Single-cycle op: `rsp_valid` first high in cycle t+2.
  - MOD: `mod_restart` high in cycle t+1; `rsp_valid` first high in cycle t+2+`MOD_CYCLES`.
  - MOD by zero: `rsp_valid` first high in cycle t+1.
- Back-to-back throughput, with `rsp_ready` held at 1: one single-cycle op every 3 cycles.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), and the in-flight op is dropped. `mod_restart` never glitches high during reset.
- `req_*` inputs are ignored outside IDLE.
- `rsp_ready` is ignored outside RESP.

## Structure
- Shared package `alu_pkg`:
  - the 3-bit op-code constants listed above;
  - the `OP_MOD` constant;
  - the state enum.
  - `my_alu` and the datapath decode use the same constants.
- One natural sub-module: `alu_wait_counter`, an 8-bit loadable down-counter with a terminal flag at value 1. Everything else lives in `alu_issue_ctrl`.

## Test plan
- AND with A = 0xF0F0_F0F0 and B = 0x0FF0_0FF0 (ALU model attached) -> `alu_op` = 000, `rsp_data` = 0x00F0_00F0, `rsp_err` = 0, `rsp_valid` exactly 2 cycles after accept.
- ADD with A = 0xFFFF_FFFF and B = 1 -> `rsp_data` = 0x0000_0000; `op_count` goes 0 -> 1.
- MOD with A = 100 and B = 7, `MOD_CYCLES` = 34 -> a single `mod_restart` pulse in cycle t+1, `rsp_data` = 2, `rsp_valid` in cycle t+36, `req_ready` low throughout.
- MOD with A = 5 and B = 0 -> no `mod_restart`; `rsp_err` = 1, `rsp_data` = 0, `rsp_valid` in cycle t+1.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles after an OR of 0x1 and 0x2 -> `rsp_data` = 0x3 stays stable, `req_ready` = 0, and a competing `req_valid` is not accepted. Release `rsp_ready` -> IDLE the next cycle.
- Assert `reset` low in the middle of WAIT_MOD -> outputs return to their reset values immediately, with no `rsp_valid`. A fresh XOR of 0xFF and 0x0F then returns 0xF0 with `op_count` = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, wait-counter width, controller states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    // ALUop encodings shared by my_alu, the datapath decode and the issue controller
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    // Width of the modulo wait counter; MOD_CYCLES must fit in it (1..255)
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        RESTART  = 3'd2,
        WAIT_MOD = 3'd3,
        RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundles the request channel, ALU drive/result and response channel of the issue controller.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes carried as plain signals.
//
// Ports (as seen from the controller, modport slave):
//   req_valid/req_ready/req_op/req_a/req_b  request channel in
//   alu_a/alu_b/alu_op/mod_restart/alu_r    ALU drive out, result in
//   rsp_valid/rsp_ready/rsp_data/rsp_err    response channel out
//   op_count                                completed-response counter
interface alu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        mod_restart;
    logic [31:0] alu_r;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] op_count;

    // Controller side
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_r, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, mod_restart,
               rsp_valid, rsp_data, rsp_err, op_count
    );

    // Sequencer / ALU side
    modport master (
        output req_valid, req_op, req_a, req_b, alu_r, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, mod_restart,
               rsp_valid, rsp_data, rsp_err, op_count
    );

endinterface

// File: rtl/alu_wait_counter.sv
// Loadable down-counter that times the iterative modulo unit; term flags the value 1.
// Latency: load/decrement take effect on the next rising edge; term is a decode of the count.
// Backpressure: none; the counter only moves on load or dec.
//
// Ports: clk, reset (async active-low), load + load_val, dec, term (count == 1).
module alu_wait_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            // Parks at zero rather than wrapping if decremented past the end
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == W'(1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one op at a time to my_alu, waits its fixed latency, and returns R on a response channel.
// Latency: response 2 cycles after accept (single-cycle ops), MOD_CYCLES+2 (MOD), 1 (MOD by zero).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, one op outstanding.
//
// Ports: clk, reset (async active-low), bus (alu_issue_ctrl_if.slave: request, ALU drive, response).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned MOD_CYCLES = 34
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mod_restart_q, mod_restart_d;
    logic [15:0] op_count_q, op_count_d;

    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_term;

    alu_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MOD_CYCLES)),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        op_count_d    = op_count_q;
        mod_restart_d = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    alu_a_d  = bus.req_a;
                    alu_b_d  = bus.req_b;
                    alu_op_d = bus.req_op;
                    if ((bus.req_op == OP_MOD) && (bus.req_b == 32'd0)) begin
                        // Divide by zero is answered directly; the ALU is never started
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else if (bus.req_op == OP_MOD) begin
                        // Restart pulse is registered so it is a clean flop output
                        mod_restart_d = 1'b1;
                        state_d       = RESTART;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                rsp_data_d = bus.alu_r;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESTART: begin
                cnt_load = 1'b1;
                state_d  = WAIT_MOD;
            end
            WAIT_MOD: begin
                // Counter runs MOD_CYCLES..1 across the WAIT_MOD cycles; R is ready at 1
                cnt_dec = 1'b1;
                if (cnt_term) begin
                    rsp_data_d = bus.alu_r;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= OP_AND;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            mod_restart_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            mod_restart_q <= mod_restart_d;
            op_count_q    <= op_count_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.mod_restart = mod_restart_q;
    assign bus.op_count    = op_count_q;

endmodule
